// File: rtl/depermute_gather_pkg.sv
// Shared constants and types for the depermute_gather block.
// Optional build macro: DEPERMUTE_CHECK_EN (enables the malformed-map checker).
package depermute_gather_pkg;

    localparam int P   = 2;  // half the lane count; N = 2*P
    localparam int MAP = 2;  // stored width of one dest index

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/depermute_gather_map_fifo.sv
// Map FIFO: DEPTH entries of one packed dest map, wrap-bit pointers, no bypass.
module depermute_gather_map_fifo #(
    parameter int DEPTH = 8,
    parameter int DW    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic [DW-1:0]            push_data,
    input  logic                     pop,
    output logic [DW-1:0]            head_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [DW-1:0] r_mem [DEPTH];
    logic          w_full;
    logic          w_push;
    logic          w_pop;

    assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign empty      = (r_wr_ptr == r_rd_ptr);
    assign push_ready = !w_full;
    assign w_push     = push_valid && !w_full;
    assign w_pop      = pop && !empty;
    assign level      = r_wr_ptr - r_rd_ptr;
    assign head_data  = r_mem[r_rd_ptr[AW-1:0]];

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/depermute_gather.sv
// Returns bank-ordered read data to lane order using dest maps queued at access issue.
// Optional build macro: DEPERMUTE_CHECK_EN (sticky err_map on non-bijective maps).
module depermute_gather
    import depermute_gather_pkg::*;
#(
    parameter int N     = 2 * P,
    parameter int W     = 1,
    parameter int SELW  = MAP,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     map_valid,
    output logic                     map_ready,
    input  logic [N*SELW-1:0]        map_bus,
    input  logic                     rsp_valid,
    output logic                     rsp_ready,
    input  logic [N*W-1:0]           rsp_bus,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N*W-1:0]           out_bus,
    output logic [$clog2(DEPTH):0]   map_level,
    output logic                     err_map
);
    localparam int LOGN = $clog2(N);

    out_state_e         r_state;
    out_state_e         w_state_nxt;
    logic [N*W-1:0]     r_out_bus;
    logic [N*SELW-1:0]  w_head;
    logic [N*W-1:0]     w_gather;
    logic               w_empty;
    logic               w_rsp_fire;
    logic [W-1:0]       w_bank [N];

    depermute_gather_map_fifo #(
        .DEPTH (DEPTH),
        .DW    (N*SELW)
    ) u_map_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (map_valid),
        .push_ready (map_ready),
        .push_data  (map_bus),
        .pop        (w_rsp_fire),
        .head_data  (w_head),
        .empty      (w_empty),
        .level      (map_level)
    );

    assign rsp_ready  = !w_empty && (!out_valid || out_ready);
    assign w_rsp_fire = rsp_valid && rsp_ready;

    // Only the low LOGN bits of each dest index select a bank.
    for (genvar g = 0; g < N; g++) begin : g_lane
        assign w_bank[g]              = rsp_bus[g*W +: W];
        assign w_gather[g*W +: W]     = w_bank[w_head[g*SELW +: LOGN]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_EMPTY;
            r_out_bus <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_rsp_fire) r_out_bus <= w_gather;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_rsp_fire)               w_state_nxt = ST_FULL;
            ST_FULL:  if (out_ready && !w_rsp_fire) w_state_nxt = ST_EMPTY;
            default:                                w_state_nxt = ST_EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (r_state == ST_FULL);
        out_bus   = r_out_bus;
    end

`ifdef DEPERMUTE_CHECK_EN
    logic [N-1:0] w_seen;
    logic         r_err_map;

    // A map of N indices onto N banks is a bijection exactly when every bank is hit.
    always_comb begin
        w_seen = '0;
        for (int b = 0; b < N; b++) begin
            for (int l = 0; l < N; l++) begin
                if (map_bus[l*SELW +: LOGN] == LOGN'(b)) w_seen[b] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_map <= 1'b0;
        end else if (map_valid && map_ready && !(&w_seen)) begin
            r_err_map <= 1'b1;
        end
    end

    assign err_map = r_err_map;
`else
    assign err_map = 1'b0;
`endif

endmodule

// File: tb/tb_depermute_gather.sv
// Directed self-checking bench for depermute_gather (N=4, SELW=2, W=8, DEPTH=8).
// Also exercises the malformed-map checker when DEPERMUTE_CHECK_EN is defined.
module tb_depermute_gather;
    localparam int N     = 4;
    localparam int SELW  = 2;
    localparam int W     = 8;
    localparam int DEPTH = 8;

    logic            clk;
    logic            rst;
    logic            map_valid;
    logic            map_ready;
    logic [N*SELW-1:0] map_bus;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [N*W-1:0]  rsp_bus;
    logic            out_valid;
    logic            out_ready;
    logic [N*W-1:0]  out_bus;
    logic [3:0]      map_level;
    logic            err_map;

    int n_vec;
    int n_err;

    // Packed maps, dest[3]..dest[0] from MSB to LSB
    localparam logic [7:0] MAP_PERM = 8'b01_11_00_10;  // [2,0,3,1]
    localparam logic [7:0] MAP_IDENT = 8'b11_10_01_00; // [0,1,2,3]
    localparam logic [7:0] MAP_REV  = 8'b00_01_10_11;  // [3,2,1,0]
    localparam logic [7:0] MAP_BAD  = 8'b11_10_00_00;  // [0,0,2,3]
    localparam logic [31:0] RSP_A   = 32'h0D0C0B0A;    // banks [10,11,12,13]
    localparam logic [31:0] RSP_B   = 32'h23222120;    // banks [0x20..0x23]

    depermute_gather #(
        .N     (N),
        .W     (W),
        .SELW  (SELW),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .map_valid (map_valid),
        .map_ready (map_ready),
        .map_bus   (map_bus),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_bus   (rsp_bus),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bus   (out_bus),
        .map_level (map_level),
        .err_map   (err_map)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; returns 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        map_valid = 1'b0;
        map_bus   = '0;
        rsp_valid = 1'b0;
        rsp_bus   = '0;
        out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_level",     32'(map_level), 32'd0);
        check("rst_map_ready", 32'(map_ready), 32'd1);
        check("rst_rsp_ready", 32'(rsp_ready), 32'd0);
        check("rst_out_bus",   out_bus,        32'd0);
        check("rst_err_map",   32'(err_map),   32'd0);

        // Basic gather with a permutation
        map_valid = 1'b1; map_bus = MAP_PERM;
        step();
        map_valid = 1'b0;
        check("perm_level", 32'(map_level), 32'd1);
        rsp_valid = 1'b1; rsp_bus = RSP_A;
        #1;
        check("perm_rsp_ready", 32'(rsp_ready), 32'd1);
        step();
        rsp_valid = 1'b0;
        check("perm_out_valid", 32'(out_valid), 32'd1);
        check("perm_out_bus",   out_bus,        32'h0B0D0A0C);
        check("perm_level0",    32'(map_level), 32'd0);
        step();
        check("perm_drain", 32'(out_valid), 32'd0);

        // Response arriving before its map is stalled, then accepted
        rsp_valid = 1'b1; rsp_bus = RSP_B;
        #1;
        check("early_rsp_ready", 32'(rsp_ready), 32'd0);
        step();
        check("early_out_valid", 32'(out_valid), 32'd0);
        map_valid = 1'b1; map_bus = MAP_IDENT;
        #1;
        check("early_no_bypass", 32'(rsp_ready), 32'd0);
        step();
        map_valid = 1'b0;
        #1;
        check("early_rsp_ready1", 32'(rsp_ready), 32'd1);
        step();
        rsp_valid = 1'b0;
        check("early_out_valid1", 32'(out_valid), 32'd1);
        check("early_out_bus",    out_bus,        RSP_B);
        step();

        // Fill FIFO to DEPTH
        map_valid = 1'b1; map_bus = MAP_REV;
        for (int i = 0; i < DEPTH; i++) step();
        check("full_map_ready", 32'(map_ready), 32'd0);
        check("full_level",     32'(map_level), 32'd8);
        // Pop while full with a push offered: push is refused
        rsp_valid = 1'b1; rsp_bus = RSP_A;
        step();
        check("full_pop_level", 32'(map_level), 32'd7);
        check("full_rev_out",   out_bus,        32'h0A0B0C0D);
        // Simultaneous push and pop: level unchanged
        step();
        check("pushpop_level", 32'(map_level), 32'd7);
        rsp_valid = 1'b0;
        step();
        map_valid = 1'b0;
        check("refill_level", 32'(map_level), 32'd8);
        rsp_valid = 1'b1;
        for (int i = 0; i < 20 && map_level != 0; i++) step();
        rsp_valid = 1'b0;
        check("drain_level", 32'(map_level), 32'd0);
        step();
        check("drain_out_valid", 32'(out_valid), 32'd0);

        // Back-to-back responses with a 3-cycle output stall
        map_valid = 1'b1; map_bus = MAP_IDENT;
        step();
        map_bus = MAP_REV;
        step();
        map_valid = 1'b0;
        out_ready = 1'b0;
        rsp_valid = 1'b1; rsp_bus = RSP_A;
        step();
        rsp_bus = RSP_B;
        for (int i = 0; i < 3; i++) begin
            check("stall_rsp_ready", 32'(rsp_ready), 32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_out_bus",   out_bus,        RSP_A);
            step();
        end
        check("stall_level", 32'(map_level), 32'd1);
        out_ready = 1'b1;
        #1;
        check("unstall_rsp_ready", 32'(rsp_ready), 32'd1);
        step();
        rsp_valid = 1'b0;
        check("second_out_valid", 32'(out_valid), 32'd1);
        check("second_out_bus",   out_bus,        32'h20212223);
        step();
        check("second_drain", 32'(out_valid), 32'd0);
        check("second_level", 32'(map_level), 32'd0);

        // Reset mid-operation
        map_valid = 1'b1; map_bus = MAP_IDENT;
        for (int i = 0; i < 4; i++) step();
        map_valid = 1'b0;
        out_ready = 1'b0;
        rsp_valid = 1'b1; rsp_bus = RSP_A;
        step();
        rsp_valid = 1'b0;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        check("pre_rst_level", 32'(map_level), 32'd3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_level",     32'(map_level), 32'd0);
        check("mid_rst_err_map",   32'(err_map),   32'd0);
        check("mid_rst_out_bus",   out_bus,        32'd0);

        // Malformed map: duplicate dest broadcasts, checker flags it if built in
        map_valid = 1'b1; map_bus = MAP_BAD;
        step();
        map_valid = 1'b0;
`ifdef DEPERMUTE_CHECK_EN
        check("bad_err_map", 32'(err_map), 32'd1);
`else
        check("bad_err_map", 32'(err_map), 32'd0);
`endif
        rsp_valid = 1'b1; rsp_bus = RSP_A;
        step();
        rsp_valid = 1'b0;
        check("bad_out_bus", out_bus, 32'h0D0C0A0A);
        map_valid = 1'b1; map_bus = MAP_IDENT;
        step();
        map_valid = 1'b0;
        step();
`ifdef DEPERMUTE_CHECK_EN
        check("bad_err_sticky", 32'(err_map), 32'd1);
`else
        check("bad_err_sticky", 32'(err_map), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
